pll_clk_monitor: RTL and testbench

Frequency monitor for the system PLL outputs. Runs on the PLL reference clock, waits for PLL lock, lets the outputs settle, then repeatedly counts rising edges of one PLL output clock over a fixed gate window. Each window produces a count, and optionally an in-range flag, so the 4.000000 MHz and 4.194528 MHz clocks can be checked at run time and in simulation.

---
 rtl/pll_clk_monitor.sv | 147 ++++++++++++++
 tb/tb_pll_clk_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_clk_monitor.sv
// PLL output frequency monitor: counts meas_clk rising edges over back-to-back refclk gate windows after lock + settle.
// Optional range check on each window count is built only when PLL_CLK_MON_RANGE_EN is defined.
module pll_clk_monitor #(
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 16,
  parameter int EXP_MIN       = 3990,
  parameter int EXP_MAX       = 4010
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             meas_clk,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             meas_busy,
  output logic             in_range,
  output logic             lost_lock
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LOAD   = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, GATE} state_t;

  logic             lock_s1_q, lock_s2_q;
  logic             meas_s1_q, meas_s2_q, meas_s3_q;
  state_t           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_vld_q, count_vld_d;
  logic             busy_q, busy_d;
  logic             in_range_q, in_range_d;
  logic             lost_q, lost_d;

  logic             locked_s;
  logic             edge_det;
  logic [CNT_W-1:0] edge_inc;
  logic             range_hit;

  assign locked_s = lock_s2_q;
  assign edge_det = meas_s2_q & ~meas_s3_q;
  assign edge_inc = (edge_det && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + 1'b1 : edge_cnt_q;

`ifdef PLL_CLK_MON_RANGE_EN
  localparam logic [CNT_W-1:0] LO = EXP_MIN[CNT_W-1:0];
  localparam logic [CNT_W-1:0] HI = EXP_MAX[CNT_W-1:0];
  assign range_hit = (edge_inc >= LO) && (edge_inc <= HI);
`else
  assign range_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    gate_d      = gate_q;
    edge_cnt_d  = edge_cnt_q;
    count_d     = count_q;
    count_vld_d = 1'b0;
    in_range_d  = in_range_q;
    lost_d      = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
        end else if (settle_q == '0) begin
          state_d    = GATE;
          edge_cnt_d = '0;
          gate_d     = GATE_LOAD;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      GATE: begin
        // Lock loss wins over a window completing in the same cycle.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
        end else if (gate_q == '0) begin
          count_d     = edge_inc;
          count_vld_d = 1'b1;
          in_range_d  = range_hit;
          edge_cnt_d  = '0;
          gate_d      = GATE_LOAD;
        end else begin
          gate_d     = gate_q - 1'b1;
          edge_cnt_d = edge_inc;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    busy_d = (state_d == SETTLE) || (state_d == GATE);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_s1_q   <= 1'b0;
      lock_s2_q   <= 1'b0;
      meas_s1_q   <= 1'b0;
      meas_s2_q   <= 1'b0;
      meas_s3_q   <= 1'b0;
      state_q     <= WAIT_LOCK;
      settle_q    <= '0;
      gate_q      <= '0;
      edge_cnt_q  <= '0;
      count_q     <= '0;
      count_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      in_range_q  <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      lock_s1_q   <= locked;
      lock_s2_q   <= lock_s1_q;
      meas_s1_q   <= meas_clk;
      meas_s2_q   <= meas_s1_q;
      meas_s3_q   <= meas_s2_q;
      state_q     <= state_d;
      settle_q    <= settle_d;
      gate_q      <= gate_d;
      edge_cnt_q  <= edge_cnt_d;
      count_q     <= count_d;
      count_vld_q <= count_vld_d;
      busy_q      <= busy_d;
      in_range_q  <= in_range_d;
      lost_q      <= lost_d;
    end
  end

  assign count       = count_q;
  assign count_valid = count_vld_q;
  assign meas_busy   = busy_q;
  assign in_range    = in_range_q;
  assign lost_lock   = lost_q;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Scoreboard bench for pll_clk_monitor: four instances (small exact-model, saturating, two default-size frequency checks).
module tb_pll_clk_monitor;

`ifdef PLL_CLK_MON_RANGE_EN
  localparam int RANGE_EN = 1;
`else
  localparam int RANGE_EN = 0;
`endif

  typedef struct {
    int cyc;
    int lo;   // lo < 0: expected count comes from the edge log of instance a
    int hi;
    int rng;
  } exp_t;

  logic refclk = 1'b0;
  logic rst = 1'b1, rst_a = 1'b1;
  logic locked_a = 1'b0, locked_b = 1'b0, locked_c = 1'b0, locked_d = 1'b0;
  logic meas_a = 1'b0, meas_b = 1'b0, meas_c = 1'b0, meas_d = 1'b0;
  logic [15:0] cnt_a, cnt_c, cnt_d;
  logic [3:0]  cnt_b;
  logic cv_a, cv_b, cv_c, cv_d;
  logic busy_a, busy_b, busy_c, busy_d;
  logic inr_a, inr_b, inr_c, inr_d;
  logic lost_a, lost_b, lost_c, lost_d;

  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  bit   done = 1'b0;
  bit   meas_a_en = 1'b0;
  logic [1:0] ph_a = 2'd0, ph_b = 2'd0;
  bit   det_a [1024];
  int   last_exp_a = 0, last_rng_a = 0;
  exp_t sbq [4][$];

  pll_clk_monitor #(.GATE_CYCLES(10), .SETTLE_CYCLES(4), .CNT_W(16), .EXP_MIN(2), .EXP_MAX(3)) u_a (
    .refclk(refclk), .rst(rst_a), .locked(locked_a), .meas_clk(meas_a), .count(cnt_a),
    .count_valid(cv_a), .meas_busy(busy_a), .in_range(inr_a), .lost_lock(lost_a));
  pll_clk_monitor #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(4), .EXP_MIN(0), .EXP_MAX(14)) u_b (
    .refclk(refclk), .rst(rst), .locked(locked_b), .meas_clk(meas_b), .count(cnt_b),
    .count_valid(cv_b), .meas_busy(busy_b), .in_range(inr_b), .lost_lock(lost_b));
  pll_clk_monitor u_c (
    .refclk(refclk), .rst(rst), .locked(locked_c), .meas_clk(meas_c), .count(cnt_c),
    .count_valid(cv_c), .meas_busy(busy_c), .in_range(inr_c), .lost_lock(lost_c));
  pll_clk_monitor u_d (
    .refclk(refclk), .rst(rst), .locked(locked_d), .meas_clk(meas_d), .count(cnt_d),
    .count_valid(cv_d), .meas_busy(busy_d), .in_range(inr_d), .lost_lock(lost_d));

  // refclk period 20000 units (50 MHz); meas_c 4.000 MHz, meas_d ~4.194528 MHz.
  always #10000 refclk = ~refclk;
  always #125000 meas_c = ~meas_c;
  always #119203 meas_d = ~meas_d;

  always @(posedge refclk) cyc <= cyc + 1;

  // refclk/4 sources; a rise driven after posedge m is seen by the detector in cycle m+2.
  always @(negedge refclk) begin
    if (meas_a_en) begin
      ph_a = ph_a + 2'd1;
      if (ph_a == 2'd2) begin
        meas_a = 1'b1;
        if (cyc + 2 < 1024) det_a[cyc + 2] = 1'b1;
      end else if (ph_a == 2'd0) begin
        meas_a = 1'b0;
      end
    end else begin
      ph_a   = 2'd0;
      meas_a = 1'b0;
    end
    ph_b   = ph_b + 2'd1;
    meas_b = ph_b[1];
  end

  task automatic chk(string nm, bit ok, int act, int lo, int hi);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d..%0d", nm, cyc, act, lo, hi);
    end
  endtask

  task automatic push(int i, int c, int lo, int hi, int r);
    exp_t e;
    e.cyc = c; e.lo = lo; e.hi = hi; e.rng = r;
    sbq[i].push_back(e);
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge refclk);
  endtask

  function automatic int model_a(int v);
    int s = 0;
    for (int k = v - 10; k < v; k++)
      if (k >= 0 && k < 1024 && det_a[k]) s++;
    return s;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 4; i++) s += sbq[i].size();
    return s;
  endfunction

  task automatic chk_reset_a(string tag);
    chk({tag, "_count"}, cnt_a == 16'd0, int'(cnt_a), 0, 0);
    chk({tag, "_valid"}, cv_a == 1'b0, int'(cv_a), 0, 0);
    chk({tag, "_busy"}, busy_a == 1'b0, int'(busy_a), 0, 0);
    chk({tag, "_in_range"}, inr_a == 1'b0, int'(inr_a), 0, 0);
    chk({tag, "_lost_lock"}, lost_a == 1'b0, int'(lost_a), 0, 0);
  endtask

  // Monitor: every count_valid pops one expectation per instance.
  always @(negedge refclk) begin : mon
    bit   v [4];
    int   c [4];
    int   r [4];
    exp_t e;
    int   elo, ehi, er;
    v = '{cv_a, cv_b, cv_c, cv_d};
    c = '{int'(cnt_a), int'(cnt_b), int'(cnt_c), int'(cnt_d)};
    r = '{int'(inr_a), int'(inr_b), int'(inr_c), int'(inr_d)};
    if (!done) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i]) begin
          if (sbq[i].size() == 0) begin
            chk($sformatf("unexpected_valid_dut%0d", i), 1'b0, 1, 0, 0);
          end else begin
            e = sbq[i].pop_front();
            if (e.lo < 0) begin
              elo = model_a(e.cyc);
              ehi = elo;
              er  = (RANGE_EN == 1 && elo >= 2 && elo <= 3) ? 1 : 0;
              last_exp_a = elo;
              last_rng_a = er;
            end else begin
              elo = e.lo; ehi = e.hi; er = e.rng;
            end
            chk($sformatf("valid_cycle_dut%0d", i), cyc == e.cyc, cyc, e.cyc, e.cyc);
            chk($sformatf("count_dut%0d", i), c[i] >= elo && c[i] <= ehi, c[i], elo, ehi);
            chk($sformatf("in_range_dut%0d", i), r[i] == er, r[i], er, er);
          end
        end
      end
    end
  end

  initial begin
    int c0, c1;
    c0 = 5;
    c1 = c0 + 50;
    wait_cyc(3);
    chk_reset_a("rst");
    chk("rst_b_count", cnt_b == 4'd0, int'(cnt_b), 0, 0);
    chk("rst_b_busy", busy_b == 1'b0, int'(busy_b), 0, 0);
    rst = 1'b0; rst_a = 1'b0; meas_a_en = 1'b1;

    wait_cyc(c0);
    locked_a = 1'b1; locked_b = 1'b1; locked_c = 1'b1; locked_d = 1'b1;
    push(0, c0 + 17, -1, -1, 0);
    push(0, c0 + 27, -1, -1, 0);
    push(0, c0 + 37, -1, -1, 0);
    push(1, c0 + 107, 15, 15, 0);
    push(1, c0 + 207, 15, 15, 0);
    push(2, c0 + 51027, 3999, 4001, RANGE_EN);
    push(3, c0 + 51027, 4194, 4195, 0);

    wait_cyc(c0 + 2);
    chk("busy_before_settle", busy_a == 1'b0, int'(busy_a), 0, 0);
    wait_cyc(c0 + 3);
    chk("busy_in_settle", busy_a == 1'b1, int'(busy_a), 1, 1);

    // Drop lock mid-window: the window due at c0+47 must be aborted.
    wait_cyc(c0 + 40);
    locked_a = 1'b0;
    wait_cyc(c0 + 42);
    chk("lost_before_fall_seen", lost_a == 1'b0, int'(lost_a), 0, 0);
    chk("busy_before_fall_seen", busy_a == 1'b1, int'(busy_a), 1, 1);
    wait_cyc(c0 + 43);
    chk("lost_after_drop", lost_a == 1'b1, int'(lost_a), 1, 1);
    chk("busy_after_drop", busy_a == 1'b0, int'(busy_a), 0, 0);
    chk("count_held", int'(cnt_a) == last_exp_a, int'(cnt_a), last_exp_a, last_exp_a);
    chk("in_range_held", int'(inr_a) == last_rng_a, int'(inr_a), last_rng_a, last_rng_a);

    wait_cyc(c1);
    locked_a = 1'b1;
    push(0, c1 + 17, -1, -1, 0);
    wait_cyc(c1 + 17);
    chk("lost_sticky", lost_a == 1'b1, int'(lost_a), 1, 1);

    // Reset mid-GATE, then full latency from the next locked_s.
    wait_cyc(c1 + 20);
    rst_a = 1'b1;
    wait_cyc(c1 + 21);
    chk_reset_a("midrst");
    rst_a = 1'b0;
    push(0, c1 + 38, -1, -1, 0);

    wait_cyc(c1 + 38);
    meas_a_en = 1'b0;
    push(0, c1 + 48, -1, -1, 0);
    push(0, c1 + 58, -1, -1, 0);
    wait_cyc(c1 + 60);
    locked_a = 1'b0;
    wait_cyc(c0 + 210);
    locked_b = 1'b0;

    while (pending() > 0 && cyc < c0 + 51060) @(negedge refclk);
    chk("scoreboard_drained", pending() == 0, pending(), 0, 0);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
